ecdsa_sequencer: RTL and testbench

- Control stage directly upstream of ecdsa_combined; owns the core's ecc_go / sign_go / verify_go handshakes.
- Accepts one operation request at a time (KEYGEN, SIGN, VERIFY) through a valid/ready port.
- Runs key generation automatically when no public key is cached, captures r/s, and returns one response per request.
- Adds a per-phase timeout so a hung core cannot stall the system.

---
 rtl/ecdsa_seq_pkg.sv | 28 ++
 rtl/ecdsa_phase_timer.sv | 30 +++
 rtl/ecdsa_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_ecdsa_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_seq_pkg.sv
// Shared types for the ECDSA sequencer: request opcodes, response status codes and FSM states.
package ecdsa_seq_pkg;

    typedef enum logic [1:0] {
        OP_KEYGEN = 2'b00,
        OP_SIGN   = 2'b01,
        OP_VERIFY = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_FAIL    = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_BADOP   = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYGEN = 3'd1,
        S_SIGN   = 3'd2,
        S_VWAIT  = 3'd3,
        S_VERIFY = 3'd4,
        S_DROP   = 3'd5,
        S_RESP   = 3'd6
    } state_e;

endpackage

// File: rtl/ecdsa_phase_timer.sv
// Per-phase watchdog: cleared on phase entry, counts while enabled, flags the last allowed cycle.
module ecdsa_phase_timer
    import ecdsa_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is asserted in the final cycle so the phase lasts exactly TIMEOUT_CYCLES.
    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/ecdsa_sequencer.sv
// Request sequencer in front of ecdsa_combined: auto-keygen, sign/verify go handshakes, per-phase timeout.
// Optional ECDSA_SEQ_SELFCHECK_EN: every successful SIGN is re-verified before the response.
module ecdsa_sequencer
    import ecdsa_seq_pkg::*;
#(
    parameter int KEY_SIZE       = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [KEY_SIZE-1:0] req_r,
    input  logic [KEY_SIZE-1:0] req_s,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic                rsp_verified,
    output logic [KEY_SIZE-1:0] rsp_r,
    output logic [KEY_SIZE-1:0] rsp_s,
    output logic                key_valid,
    output logic                ecc_go,
    output logic                sign_go,
    output logic                verify_go,
    input  logic                ecc_done,
    input  logic                sign_done,
    input  logic                verify_done,
    input  logic                verify_ready,
    input  logic                verified,
    input  logic                failure,
    input  logic [KEY_SIZE-1:0] r_sign,
    input  logic [KEY_SIZE-1:0] s_sign,
    output logic [KEY_SIZE-1:0] verifying_r,
    output logic [KEY_SIZE-1:0] verifying_s
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              r_state, w_next;
    op_e                 r_op;
    status_e             r_status, w_status_nx;
    logic                r_verified, r_key_valid, r_chk;
    logic [KEY_SIZE-1:0] r_rsp_r, r_rsp_s, r_vr, r_vs;
    logic                w_accept, w_status_ld, w_ver_ld, w_cap_sig;
    logic                w_key_set, w_key_clr, w_chk_set, w_chk_clr;
    logic                w_in_phase, w_expired;

    assign w_in_phase = (r_state == S_KEYGEN) || (r_state == S_SIGN) ||
                        (r_state == S_VWAIT)  || (r_state == S_VERIFY);

    ecdsa_phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_next != r_state),
        .i_en     (w_in_phase),
        .o_expired(w_expired)
    );

    // Handshake outputs decode straight from state; rst gates them so go drops in the reset cycle.
    assign req_ready    = (r_state == S_IDLE)   && !rst;
    assign rsp_valid    = (r_state == S_RESP)   && !rst;
    assign ecc_go       = (r_state == S_KEYGEN) && !rst;
    assign sign_go      = (r_state == S_SIGN)   && !rst;
    assign verify_go    = (r_state == S_VERIFY) && !rst;
    assign rsp_status   = r_status;
    assign rsp_verified = r_verified;
    assign rsp_r        = r_rsp_r;
    assign rsp_s        = r_rsp_s;
    assign key_valid    = r_key_valid;
    assign verifying_r  = r_vr;
    assign verifying_s  = r_vs;
    assign w_accept     = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_status_ld = 1'b0;
        w_status_nx = r_status;
        w_ver_ld    = 1'b0;
        w_cap_sig   = 1'b0;
        w_key_set   = 1'b0;
        w_key_clr   = 1'b0;
        w_chk_set   = 1'b0;
        w_chk_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_e'(req_op))
                        OP_RSVD: begin
                            w_next      = S_RESP;
                            w_status_ld = 1'b1;
                            w_status_nx = ST_BADOP;
                        end
                        OP_KEYGEN: begin
                            w_next    = S_KEYGEN;
                            w_key_clr = 1'b1;
                        end
                        default: begin
                            if (!r_key_valid)             w_next = S_KEYGEN;
                            else if (req_op == OP_SIGN)   w_next = S_SIGN;
                            else                          w_next = S_VWAIT;
                        end
                    endcase
                end
            end
            S_KEYGEN: begin
                if (ecc_done) begin
                    w_key_set = 1'b1;
                    if (r_op == OP_KEYGEN) begin
                        w_next      = S_DROP;
                        w_status_ld = 1'b1;
                        w_status_nx = ST_OK;
                    end else if (r_op == OP_SIGN) begin
                        w_next = S_SIGN;
                    end else begin
                        w_next = S_VWAIT;
                    end
                end else if (w_expired) begin
                    w_next      = S_DROP;
                    w_status_ld = 1'b1;
                    w_status_nx = ST_TIMEOUT;
                end
            end
            S_SIGN: begin
                w_status_ld = failure || sign_done || w_expired;
                if (failure) begin
                    w_next      = S_DROP;
                    w_status_nx = ST_FAIL;
                end else if (sign_done) begin
                    w_next      = S_DROP;
                    w_status_nx = ST_OK;
                    w_cap_sig   = 1'b1;
`ifdef ECDSA_SEQ_SELFCHECK_EN
                    w_chk_set   = 1'b1;
`endif
                end else if (w_expired) begin
                    w_next      = S_DROP;
                    w_status_nx = ST_TIMEOUT;
                end
            end
            S_VWAIT: begin
                if (verify_ready) begin
                    w_next = S_VERIFY;
                end else if (w_expired) begin
                    w_next      = S_DROP;
                    w_status_ld = 1'b1;
                    w_status_nx = ST_TIMEOUT;
                end
            end
            S_VERIFY: begin
                if (verify_done) begin
                    w_next      = S_DROP;
                    w_ver_ld    = 1'b1;
                    w_status_ld = 1'b1;
                    // A rejected self-check turns a signed result into FAIL; plain VERIFY stays OK.
                    w_status_nx = (r_op == OP_SIGN && !verified) ? ST_FAIL : ST_OK;
                end else if (w_expired) begin
                    w_next      = S_DROP;
                    w_status_ld = 1'b1;
                    w_status_nx = ST_TIMEOUT;
                end
            end
            S_DROP: begin
                if (r_chk) begin
                    w_next    = S_VWAIT;
                    w_chk_clr = 1'b1;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= OP_KEYGEN;
            r_status    <= ST_OK;
            r_verified  <= 1'b0;
            r_key_valid <= 1'b0;
            r_chk       <= 1'b0;
            r_rsp_r     <= '0;
            r_rsp_s     <= '0;
            r_vr        <= '0;
            r_vs        <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= op_e'(req_op);
                r_vr       <= req_r;
                r_vs       <= req_s;
                r_status   <= ST_OK;
                r_verified <= 1'b0;
                r_rsp_r    <= '0;
                r_rsp_s    <= '0;
            end
            if (w_status_ld) r_status <= w_status_nx;
            if (w_ver_ld)    r_verified <= verified;
            if (w_cap_sig) begin
                r_rsp_r <= r_sign;
                r_rsp_s <= s_sign;
            end
            if (w_chk_set) begin
                r_chk <= 1'b1;
                r_vr  <= r_sign;
                r_vs  <= s_sign;
            end else if (w_chk_clr) begin
                r_chk <= 1'b0;
            end
            if (w_key_clr)      r_key_valid <= 1'b0;
            else if (w_key_set) r_key_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ecdsa_sequencer.sv
// Self-checking bench for ecdsa_sequencer with a behavioural core stub (toy curve, fixed signature).
module tb_ecdsa_sequencer;

    localparam int KS  = 64;
    localparam int TO  = 16;
    localparam logic [KS-1:0] SIG_R = 64'd4;
    localparam logic [KS-1:0] SIG_S = 64'd5;
    localparam int ECC_LAT = 5, SIGN_LAT = 6, VER_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [KS-1:0] req_r = '0, req_s = '0;
    logic req_ready, rsp_valid, rsp_verified, key_valid, ecc_go, sign_go, verify_go;
    logic [1:0] rsp_status;
    logic [KS-1:0] rsp_r, rsp_s, verifying_r, verifying_s;
    logic ecc_done = 1'b0, sign_done = 1'b0, verify_done = 1'b0, verified = 1'b0, failure = 1'b0;
    logic verify_ready = 1'b1;
    logic [KS-1:0] r_sign = SIG_R, s_sign = SIG_S;

    bit hang_sign = 1'b0, fail_sign = 1'b0;
    int ecc_cnt = 0, sign_cnt = 0, ver_cnt = 0;

    int n_vec = 0, n_err = 0;
    int ecc_rises = 0, ver_rises = 0, sign_rises = 0, sign_hi = 0, onehot_viol = 0, overlap_viol = 0;
    logic p_ecc = 1'b0, p_sign = 1'b0, p_ver = 1'b0;

    typedef struct {
        logic [1:0]    st;
        logic          ver;
        logic [KS-1:0] r;
        logic [KS-1:0] s;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ecdsa_sequencer #(.KEY_SIZE(KS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_r(req_r), .req_s(req_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_verified(rsp_verified), .rsp_r(rsp_r), .rsp_s(rsp_s),
        .key_valid(key_valid), .ecc_go(ecc_go), .sign_go(sign_go), .verify_go(verify_go),
        .ecc_done(ecc_done), .sign_done(sign_done), .verify_done(verify_done),
        .verify_ready(verify_ready), .verified(verified), .failure(failure),
        .r_sign(r_sign), .s_sign(s_sign),
        .verifying_r(verifying_r), .verifying_s(verifying_s)
    );

    // Core stub: each done rises after a fixed latency of go and is held until go drops.
    always @(posedge clk) begin
        if (ecc_go) begin
            if (ecc_cnt == ECC_LAT) ecc_done <= 1'b1;
            else ecc_cnt <= ecc_cnt + 1;
        end else begin
            ecc_cnt <= 0; ecc_done <= 1'b0;
        end
        if (sign_go && !hang_sign) begin
            if (sign_cnt == SIGN_LAT) begin
                sign_done <= 1'b1; failure <= fail_sign;
            end else sign_cnt <= sign_cnt + 1;
        end else begin
            sign_cnt <= 0; sign_done <= 1'b0; failure <= 1'b0;
        end
        if (verify_go) begin
            if (ver_cnt == VER_LAT) begin
                verify_done <= 1'b1;
                verified    <= (verifying_r == SIG_R) && (verifying_s == SIG_S);
            end else ver_cnt <= ver_cnt + 1;
        end else begin
            ver_cnt <= 0; verify_done <= 1'b0; verified <= 1'b0;
        end
    end

    always @(posedge clk) begin
        p_ecc <= ecc_go; p_sign <= sign_go; p_ver <= verify_go;
        if (ecc_go && !p_ecc) ecc_rises <= ecc_rises + 1;
        if (sign_go && !p_sign) sign_rises <= sign_rises + 1;
        if (verify_go && !p_ver) ver_rises <= ver_rises + 1;
        if (sign_go) sign_hi <= sign_hi + 1;
        if ($countones({ecc_go, sign_go, verify_go}) > 1) onehot_viol <= onehot_viol + 1;
        if (rsp_valid && req_ready) overlap_viol <= overlap_viol + 1;
    end

    task automatic send(input logic [1:0] op, input logic [KS-1:0] r, input logic [KS-1:0] s);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_r = r; req_s = s;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL req_accept actual=req_ready low required=accepted within 100 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got, output int cyc);
        got = 1'b0; cyc = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, rsp_valid, ecc_go, sign_go, verify_go, key_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl actual=%b required=000000",
                     {req_ready, rsp_valid, ecc_go, sign_go, verify_go, key_valid});
        end
        n_vec++;
        if ({rsp_status, rsp_verified, rsp_r, rsp_s, verifying_r, verifying_s} !== '0) begin
            n_err++;
            $display("FAIL reset_data actual=st %0d r %0h vr %0h required=all zero",
                     rsp_status, rsp_r, verifying_r);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready actual=%b required=1", req_ready);
        end
    endtask

    task automatic test_sign_keygen();
        bit got; int cyc; exp_t e; int e0, v0;
        e0 = ecc_rises; v0 = ver_rises;
`ifdef ECDSA_SEQ_SELFCHECK_EN
        sb.push_back('{st: 2'b00, ver: 1'b1, r: SIG_R, s: SIG_S});
`else
        sb.push_back('{st: 2'b00, ver: 1'b0, r: SIG_R, s: SIG_S});
`endif
        send(2'b01, '0, '0);
        wait_rsp(got, cyc);
        n_vec++;
        if (!got) begin
            n_err++; void'(sb.pop_front());
            $display("FAIL sign_rsp actual=no response required=response");
        end else begin
            e = sb.pop_front();
            n_vec++;
            if ({rsp_status, rsp_verified} !== {e.st, e.ver}) begin
                n_err++;
                $display("FAIL sign_status actual=%0d/%b required=%0d/%b", rsp_status, rsp_verified, e.st, e.ver);
            end
            n_vec++;
            if (rsp_r !== e.r || rsp_s !== e.s) begin
                n_err++;
                $display("FAIL sign_sig actual=%0h,%0h required=%0h,%0h", rsp_r, rsp_s, e.r, e.s);
            end
            ack_rsp();
        end
        n_vec++;
        if (key_valid !== 1'b1 || ecc_rises - e0 !== 1) begin
            n_err++;
            $display("FAIL sign_keygen actual=kv %b rises %0d required=kv 1 rises 1", key_valid, ecc_rises - e0);
        end
        n_vec++;
`ifdef ECDSA_SEQ_SELFCHECK_EN
        if (ver_rises - v0 !== 1) begin
            n_err++;
            $display("FAIL sign_selfcheck actual=%0d verify pulses required=1", ver_rises - v0);
        end
`else
        if (ver_rises - v0 !== 0) begin
            n_err++;
            $display("FAIL sign_noverify actual=%0d verify pulses required=0", ver_rises - v0);
        end
`endif
    endtask

    task automatic test_verify(input logic [KS-1:0] r, input logic [KS-1:0] s, input logic exp_ver);
        bit got; int cyc; exp_t e; int e0;
        e0 = ecc_rises;
        sb.push_back('{st: 2'b00, ver: exp_ver, r: '0, s: '0});
        send(2'b10, r, s);
        wait_rsp(got, cyc);
        n_vec++;
        if (!got) begin
            n_err++; void'(sb.pop_front());
            $display("FAIL verify_rsp actual=no response required=response");
        end else begin
            e = sb.pop_front();
            n_vec++;
            if ({rsp_status, rsp_verified} !== {e.st, e.ver}) begin
                n_err++;
                $display("FAIL verify_result r=%0h s=%0h actual=%0d/%b required=%0d/%b",
                         r, s, rsp_status, rsp_verified, e.st, e.ver);
            end
            ack_rsp();
        end
        n_vec++;
        if (ecc_rises - e0 !== 0) begin
            n_err++;
            $display("FAIL verify_nokeygen actual=%0d ecc_go pulses required=0", ecc_rises - e0);
        end
    endtask

    task automatic test_badop();
        bit got; int cyc; exp_t e; int g0;
        g0 = ecc_rises + sign_rises + ver_rises;
        sb.push_back('{st: 2'b11, ver: 1'b0, r: '0, s: '0});
        send(2'b11, 64'hAA, 64'hBB);
        wait_rsp(got, cyc);
        n_vec++;
        if (!got || cyc > 2) begin
            n_err++;
            $display("FAIL badop_latency actual=got %b after %0d cycles required=within 2", got, cyc);
        end
        e = sb.pop_front();
        n_vec++;
        if (rsp_status !== e.st) begin
            n_err++;
            $display("FAIL badop_status actual=%0d required=%0d", rsp_status, e.st);
        end
        if (got) ack_rsp();
        n_vec++;
        if (ecc_rises + sign_rises + ver_rises - g0 !== 0) begin
            n_err++;
            $display("FAIL badop_go actual=%0d go pulses required=0", ecc_rises + sign_rises + ver_rises - g0);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int cyc; exp_t e;
        logic [1:0] ops [3];
        logic [KS-1:0] rs [3];
        ops = '{2'b10, 2'b11, 2'b10};
        rs  = '{SIG_R, 64'd0, 64'd9};
        sb.push_back('{st: 2'b00, ver: 1'b1, r: '0, s: '0});
        sb.push_back('{st: 2'b11, ver: 1'b0, r: '0, s: '0});
        sb.push_back('{st: 2'b00, ver: 1'b0, r: '0, s: '0});
        for (int k = 0; k < 3; k++) begin
            send(ops[k], rs[k], SIG_S);
            wait_rsp(got, cyc);
            e = sb.pop_front();
            n_vec++;
            if (!got || {rsp_status, rsp_verified} !== {e.st, e.ver}) begin
                n_err++;
                $display("FAIL b2b_%0d actual=got %b %0d/%b required=%0d/%b", k, got, rsp_status, rsp_verified, e.st, e.ver);
            end
            if (got) ack_rsp();
        end
    endtask

    task automatic test_failure();
        bit got; int cyc; exp_t e;
        fail_sign = 1'b1;
        sb.push_back('{st: 2'b01, ver: 1'b0, r: '0, s: '0});
        send(2'b01, '0, '0);
        wait_rsp(got, cyc);
        e = sb.pop_front();
        n_vec++;
        if (!got || rsp_status !== e.st || rsp_r !== e.r) begin
            n_err++;
            $display("FAIL sign_failure actual=got %b st %0d r %0h required=st %0d r 0", got, rsp_status, rsp_r, e.st);
        end
        if (got) ack_rsp();
        fail_sign = 1'b0;
    endtask

    task automatic test_timeout();
        bit got; int cyc; exp_t e; int h0;
        h0 = sign_hi;
        hang_sign = 1'b1;
        sb.push_back('{st: 2'b10, ver: 1'b0, r: '0, s: '0});
        send(2'b01, '0, '0);
        wait_rsp(got, cyc);
        e = sb.pop_front();
        n_vec++;
        if (!got || rsp_status !== e.st) begin
            n_err++;
            $display("FAIL timeout_status actual=got %b st %0d required=%0d", got, rsp_status, e.st);
        end
        n_vec++;
        if (sign_hi - h0 !== TO) begin
            n_err++;
            $display("FAIL timeout_go_cycles actual=%0d required=%0d", sign_hi - h0, TO);
        end
        if (got) ack_rsp();
        hang_sign = 1'b0;
        sb.push_back('{st: 2'b00, ver: 1'b0, r: '0, s: '0});
        send(2'b00, '0, '0);
        wait_rsp(got, cyc);
        e = sb.pop_front();
        n_vec++;
        if (!got || rsp_status !== e.st || key_valid !== 1'b1) begin
            n_err++;
            $display("FAIL after_timeout_keygen actual=got %b st %0d kv %b required=st 0 kv 1", got, rsp_status, key_valid);
        end
        if (got) ack_rsp();
    endtask

    task automatic test_reset_mid_sign();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sign_go) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL rst_mid_start actual=sign_go never high required=sign_go high");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({ecc_go, sign_go, verify_go, key_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid_go actual=%b required=0000", {ecc_go, sign_go, verify_go, key_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_idle actual=rdy %b vld %b kv %b required=1 0 0", req_ready, rsp_valid, key_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sign_keygen();
        test_verify(SIG_R, SIG_S, 1'b1);
        test_verify(64'd1, 64'd2, 1'b0);
        test_back_to_back();
        test_badop();
        test_failure();
        test_timeout();
        test_reset_mid_sign();
        n_vec++;
        if (onehot_viol !== 0 || overlap_viol !== 0) begin
            n_err++;
            $display("FAIL exclusivity actual=onehot %0d overlap %0d required=0 0", onehot_viol, overlap_viol);
        end
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
